// File: rtl/adc_spi_arbiter.sv
// ---------------------------------------------------------------------------
// adc_spi_arbiter
//
// Shares the single ADC configuration SPI port between N_REQ requesters
// (run/power-down control, coarse-gain control, init sequencer, ...).
// Each requester presents one 16-bit {addr[4:0], data[10:0]} word with a
// req/ack handshake. A round-robin arbiter picks one word at a time and a
// divided-clock serialiser sends it MSB first on SCLK/SDATA/SEN.
//
// Parameters
//   N_REQ    number of requesters (1..8)
//   CLK_DIV  clocks per SCLK half-period (1..255)
//   GAP      minimum clocks with SEN high between frames (0..255)
//
// Ports
//   clock    in   system clock, all logic on posedge
//   reset    in   asynchronous active-low reset
//   req      in   req[i]=1: requester i has a word pending
//   wr_word  in   word i = wr_word[16*i+15:16*i], stable while req[i]=1
//   ack      out  one-clock pulse: word i captured, req[i] may drop
//   busy     out  1 from grant until the inter-frame gap has expired
//   SCLK     out  SPI clock, idle high
//   SDATA    out  SPI data, MSB first, changes while SCLK rises
//   SEN      out  SPI enable, active low, idle high
// ---------------------------------------------------------------------------
module adc_spi_arbiter #(
  parameter int N_REQ   = 3,
  parameter int CLK_DIV = 1,
  parameter int GAP     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  wr_word,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic                 SCLK,
  output logic                 SDATA,
  output logic                 SEN
);

  localparam int                IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]        DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0]        GAP_RELOAD = 8'(GAP - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HI,
    ST_LO,
    ST_END,
    ST_GAP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  grant;
  logic              grant_valid;
  logic [15:0]       grant_word;
  logic [15:0]       shreg;
  logic [3:0]        bit_cnt;
  logic [7:0]        div_cnt;
  logic              div_done;

  assign div_done = (div_cnt == 8'd0);

  // Round-robin search: start one past the last granted index and wrap, so
  // the most recently served requester is considered last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!grant_valid && req[IDX_W'(idx)]) begin
        grant_valid = 1'b1;
        grant       = IDX_W'(idx);
      end
    end
  end

  // Word mux for the granted requester, written as a constant-index loop so
  // every slice is static.
  always_comb begin
    grant_word = 16'h0000;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        grant_word = wr_word[16*i +: 16];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. HI/LO/GAP leave only when the divider reaches 0.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant_valid) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_HI;
      ST_HI:   if (div_done) state_next = ST_LO;
      ST_LO:   if (div_done) state_next = (bit_cnt == 4'd15) ? ST_END : ST_HI;
      ST_END:  state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (div_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered pin outputs. The pins are decoded from the next
  // state so they change on the same edge as the state itself: SEN falls and
  // ack rises together on entry to LOAD, SCLK is low only in LO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack        <= '0;
      busy       <= 1'b0;
      SCLK       <= 1'b1;
      SDATA      <= 1'b0;
      SEN        <= 1'b1;
      last_grant <= LAST_IDX;
      shreg      <= 16'h0000;
      bit_cnt    <= 4'd0;
      div_cnt    <= 8'd0;
    end else begin
      ack  <= '0;
      busy <= (state_next != ST_IDLE);
      SEN  <= !((state_next == ST_LOAD) || (state_next == ST_HI) ||
                (state_next == ST_LO));
      SCLK <= (state_next != ST_LO);
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            last_grant <= grant;
            shreg      <= grant_word;
            ack[grant] <= 1'b1;
          end
        end
        ST_LOAD: begin
          div_cnt <= DIV_RELOAD;
          SDATA   <= shreg[4'd15 - bit_cnt];
        end
        ST_HI: begin
          div_cnt <= div_done ? DIV_RELOAD : div_cnt - 8'd1;
        end
        ST_LO: begin
          // The next bit is driven as SCLK rises, so SDATA is stable across
          // the whole following LO phase.
          if (div_done) begin
            div_cnt <= DIV_RELOAD;
            if (bit_cnt != 4'd15) begin
              bit_cnt <= bit_cnt + 4'd1;
              SDATA   <= shreg[4'd14 - bit_cnt];
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_END: begin
          bit_cnt <= 4'd0;
          div_cnt <= GAP_RELOAD;
        end
        ST_GAP: begin
          div_cnt <= div_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_arbiter
//
// Directed bench for adc_spi_arbiter. Instance dut runs CLK_DIV=1, GAP=4 and
// carries most scenarios; instance dut4 runs CLK_DIV=4, GAP=4 for the slow
// divider timing. Monitors decode the SPI pins on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_adc_spi_arbiter;

  logic        clock;
  logic        reset;

  logic [2:0]  req;
  logic [47:0] wr_word;
  logic [2:0]  ack;
  logic        busy, sclk, sdata, sen;

  logic [2:0]  req4;
  logic [47:0] wr_word4;
  logic [2:0]  ack4;
  logic        busy4, sclk4, sdata4, sen4;

  int checks   = 0;
  int failures = 0;

  // Decoded traffic of dut.
  logic [15:0] frame_q[$];
  int          len_q[$];
  int          nbits_q[$];
  int          ack_q[$];
  int          gap_q[$];
  int          bad_ack = 0;
  int          mon_nb  = 0;

  // Decoded traffic of dut4.
  logic [15:0] frame4_q[$];
  int          len4_q[$];
  int          nbits4_q[$];
  int          gap4_q[$];
  int          hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;

  adc_spi_arbiter #(.N_REQ(3), .CLK_DIV(1), .GAP(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .wr_word(wr_word),
    .ack    (ack),
    .busy   (busy),
    .SCLK   (sclk),
    .SDATA  (sdata),
    .SEN    (sen)
  );

  adc_spi_arbiter #(.N_REQ(3), .CLK_DIV(4), .GAP(4)) dut4 (
    .clock  (clock),
    .reset  (reset),
    .req    (req4),
    .wr_word(wr_word4),
    .ack    (ack4),
    .busy   (busy4),
    .SCLK   (sclk4),
    .SDATA  (sdata4),
    .SEN    (sen4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor for dut: frame word (bits taken at SCLK falls), SEN low length,
  // SEN high length before each frame, and every ack pulse.
  initial begin : mon_main
    logic        prev_sen, prev_sclk;
    logic [15:0] sh;
    int          lo, hi;
    prev_sen = 1'b1; prev_sclk = 1'b1; sh = 16'h0; lo = 0; hi = 0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        prev_sen = 1'b1; prev_sclk = 1'b1; mon_nb = 0; lo = 0; hi = 0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (ack[i] === 1'b1) begin
            ack_q.push_back(i);
            if (sen !== 1'b0 || busy !== 1'b1) bad_ack++;
          end
        end
        if (!prev_sen && sen) begin
          frame_q.push_back(sh); len_q.push_back(lo); nbits_q.push_back(mon_nb);
          hi = 0;
        end
        if (prev_sen && !sen) begin
          gap_q.push_back(hi); lo = 0; mon_nb = 0; sh = 16'h0;
        end
        if (!sen) begin
          lo++;
          if (prev_sclk && !sclk) begin
            sh = {sh[14:0], sdata}; mon_nb++;
          end
        end else begin
          hi++;
        end
        prev_sen = sen; prev_sclk = sclk;
      end
    end
  end

  // Monitor for dut4: as above plus SCLK run lengths inside a frame. A high
  // run is only measured if it began at an SCLK rise (the first one in a
  // frame also includes the LOAD clock).
  initial begin : mon_slow
    logic        prev_sen, prev_sclk, from_rise;
    logic [15:0] sh;
    int          lo, hi, nb, run;
    prev_sen = 1'b1; prev_sclk = 1'b1; from_rise = 1'b0;
    sh = 16'h0; lo = 0; hi = 0; nb = 0; run = 0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        prev_sen = 1'b1; prev_sclk = 1'b1; lo = 0; hi = 0; nb = 0;
      end else begin
        if (!prev_sen && sen4) begin
          frame4_q.push_back(sh); len4_q.push_back(lo); nbits4_q.push_back(nb);
          hi = 0;
        end
        if (prev_sen && !sen4) begin
          gap4_q.push_back(hi); lo = 0; nb = 0; sh = 16'h0; run = 0;
          from_rise = 1'b0;
        end
        if (!sen4) begin
          lo++;
          if (sclk4 !== prev_sclk) begin
            if (sclk4) begin
              if (run < lo_min) lo_min = run;
              if (run > lo_max) lo_max = run;
              from_rise = 1'b1;
            end else begin
              sh = {sh[14:0], sdata4}; nb++;
              if (from_rise) begin
                if (run < hi_min) hi_min = run;
                if (run > hi_max) hi_max = run;
              end
            end
            run = 1;
          end else begin
            run++;
          end
        end else begin
          hi++;
        end
        prev_sen = sen4; prev_sclk = sclk4;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic clear_logs();
    frame_q.delete(); len_q.delete(); nbits_q.delete(); ack_q.delete();
    gap_q.delete(); bad_ack = 0;
  endtask

  // Runs dut until n frames are logged or the budget expires; optionally
  // releases each req bit in the clock its ack is seen.
  task automatic run_until_frames(input int n, input int budget, input bit drop);
    for (int c = 0; c < budget && frame_q.size() < n; c++) begin
      @(negedge clock);
      if (drop) req = req & ~ack;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 3'b000; wr_word = '0; req4 = 3'b000; wr_word4 = '0;
    repeat (3) @(negedge clock);
    checks++; if (sen !== 1'b1) begin failures++; $display("[TB] FAIL reset_sen actual=%b required=1", sen); end
    checks++; if (sclk !== 1'b1) begin failures++; $display("[TB] FAIL reset_sclk actual=%b required=1", sclk); end
    checks++; if (sdata !== 1'b0) begin failures++; $display("[TB] FAIL reset_sdata actual=%b required=0", sdata); end
    checks++; if (ack !== 3'b000) begin failures++; $display("[TB] FAIL reset_ack actual=%b required=000", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (sen4 !== 1'b1 || sclk4 !== 1'b1) begin failures++; $display("[TB] FAIL reset_slow_pins actual=%b%b required=11", sen4, sclk4); end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0 || sen !== 1'b1) begin failures++; $display("[TB] FAIL idle_no_req actual=busy%b_sen%b required=busy0_sen1", busy, sen); end
  endtask

  task automatic test_single_frame();
    bit   got;
    logic prev_sen_s, sen_before;
    clear_logs();
    got = 1'b0; prev_sen_s = sen; sen_before = 1'b0;
    wr_word[15:0] = 16'h0010; req = 3'b001;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (ack[0]) begin got = 1'b1; sen_before = prev_sen_s; req[0] = 1'b0; end
      prev_sen_s = sen;
    end
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL single_ack_seen actual=%b required=1", got); end
    checks++; if (sen_before !== 1'b1) begin failures++; $display("[TB] FAIL single_sen_falls_with_ack actual_prev_sen=%b required=1", sen_before); end
    run_until_frames(1, 100, 1'b1);
    checks++; if (frame_q.size() != 1) begin failures++; $display("[TB] FAIL single_frames actual=%0d required=1", frame_q.size()); end
    if (frame_q.size() >= 1) begin
      checks++; if (frame_q[0] !== 16'h0010) begin failures++; $display("[TB] FAIL single_word actual=%h required=0010", frame_q[0]); end
      checks++; if (len_q[0] != 33) begin failures++; $display("[TB] FAIL single_sen_low actual=%0d required=33", len_q[0]); end
      checks++; if (nbits_q[0] != 16) begin failures++; $display("[TB] FAIL single_sclk_falls actual=%0d required=16", nbits_q[0]); end
    end
    checks++; if (ack_q.size() != 1 || bad_ack != 0) begin failures++; $display("[TB] FAIL single_ack_pulses actual=%0d_bad%0d required=1_bad0", ack_q.size(), bad_ack); end
    repeat (8) @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after_gap actual=%b required=0", busy); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_w[4];
    int          exp_a[4];
    int          nack;
    exp_w[0] = 16'hA5C3; exp_w[1] = 16'h1234; exp_w[2] = 16'hFFFE; exp_w[3] = 16'hA5C3;
    exp_a[0] = 0; exp_a[1] = 1; exp_a[2] = 2; exp_a[3] = 0;
    reset = 1'b0; @(negedge clock); @(negedge clock); reset = 1'b1; @(negedge clock);
    clear_logs();
    wr_word = {16'hFFFE, 16'h1234, 16'hA5C3}; req = 3'b111; nack = 0;
    for (int c = 0; c < 400 && nack < 4; c++) begin
      @(negedge clock);
      if (ack != 3'b000) nack++;
      if (nack == 4) req = 3'b000;
    end
    req = 3'b000;
    run_until_frames(4, 200, 1'b1);
    checks++; if (frame_q.size() != 4 || ack_q.size() != 4) begin failures++; $display("[TB] FAIL rr_counts actual=%0d_frames_%0d_acks required=4_4", frame_q.size(), ack_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < frame_q.size()) begin
        checks++; if (frame_q[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL rr_word%0d actual=%h required=%h", i, frame_q[i], exp_w[i]); end
      end
      if (i < ack_q.size()) begin
        checks++; if (ack_q[i] != exp_a[i]) begin failures++; $display("[TB] FAIL rr_ack%0d actual=%0d required=%0d", i, ack_q[i], exp_a[i]); end
      end
    end
    repeat (10) @(negedge clock);
  endtask

  task automatic test_priority_wrap();
    bit got;
    clear_logs();
    got = 1'b0;
    wr_word[47:32] = 16'h2C01; req = 3'b100;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (ack[2]) begin
        got = 1'b1; req = 3'b101;
        wr_word[15:0] = 16'h0A0A; wr_word[47:32] = 16'h7007;
      end
    end
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL prio_first_ack actual=%b required=1", got); end
    run_until_frames(3, 300, 1'b1);
    checks++; if (frame_q.size() != 3) begin failures++; $display("[TB] FAIL prio_frames actual=%0d required=3", frame_q.size()); end
    if (ack_q.size() == 3) begin
      checks++; if (ack_q[1] != 0) begin failures++; $display("[TB] FAIL prio_second_grant actual=%0d required=0", ack_q[1]); end
      checks++; if (ack_q[2] != 2) begin failures++; $display("[TB] FAIL prio_third_grant actual=%0d required=2", ack_q[2]); end
    end else begin
      checks++; failures++; $display("[TB] FAIL prio_ack_count actual=%0d required=3", ack_q.size());
    end
    if (frame_q.size() == 3) begin
      checks++; if (frame_q[1] !== 16'h0A0A || frame_q[2] !== 16'h7007) begin failures++; $display("[TB] FAIL prio_words actual=%h_%h required=0a0a_7007", frame_q[1], frame_q[2]); end
    end
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset_mid_frame();
    bit reached;
    clear_logs();
    reached = 1'b0;
    wr_word[31:16] = 16'h5A5A; req = 3'b010;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(negedge clock);
      req = req & ~ack;
      if (mon_nb >= 8 && sen === 1'b0) reached = 1'b1;
    end
    checks++; if (reached !== 1'b1 || sen !== 1'b0) begin failures++; $display("[TB] FAIL midreset_in_frame actual=%b_sen%b required=1_sen0", reached, sen); end
    reset = 1'b0; req = 3'b000;
    #1;
    checks++; if (sen !== 1'b1) begin failures++; $display("[TB] FAIL midreset_sen actual=%b required=1", sen); end
    checks++; if (sclk !== 1'b1) begin failures++; $display("[TB] FAIL midreset_sclk actual=%b required=1", sclk); end
    checks++; if (sdata !== 1'b0) begin failures++; $display("[TB] FAIL midreset_sdata actual=%b required=0", sdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy actual=%b required=0", busy); end
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    clear_logs();
    wr_word[15:0] = 16'h0F0F; req = 3'b011;
    run_until_frames(2, 300, 1'b1);
    checks++; if (ack_q.size() < 1 || ack_q[0] != 0) begin failures++; $display("[TB] FAIL midreset_first_grant actual=%0d required=0", (ack_q.size() > 0) ? ack_q[0] : -1); end
    checks++; if (frame_q.size() != 2) begin failures++; $display("[TB] FAIL midreset_frames actual=%0d required=2", frame_q.size()); end
    if (frame_q.size() == 2) begin
      checks++; if (frame_q[0] !== 16'h0F0F || frame_q[1] !== 16'h5A5A) begin failures++; $display("[TB] FAIL midreset_words actual=%h_%h required=0f0f_5a5a", frame_q[0], frame_q[1]); end
    end
    repeat (10) @(negedge clock);
  endtask

  task automatic test_dropped_req();
    bit reached;
    clear_logs();
    reached = 1'b0;
    wr_word[15:0] = 16'hC3A5; req = 3'b001;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(negedge clock);
      req = req & ~ack;
      if (mon_nb >= 4 && sen === 1'b0) reached = 1'b1;
    end
    checks++; if (reached !== 1'b1) begin failures++; $display("[TB] FAIL drop_in_frame actual=%b required=1", reached); end
    wr_word[31:16] = 16'hDEAD; req[1] = 1'b1;
    @(negedge clock);
    req[1] = 1'b0;
    run_until_frames(1, 200, 1'b1);
    repeat (60) @(negedge clock);
    checks++; if (frame_q.size() != 1) begin failures++; $display("[TB] FAIL drop_frames actual=%0d required=1", frame_q.size()); end
    checks++; if (ack_q.size() != 1 || (ack_q.size() == 1 && ack_q[0] != 0)) begin failures++; $display("[TB] FAIL drop_acks actual=%0d required=1_on_index0", ack_q.size()); end
    if (frame_q.size() >= 1) begin
      checks++; if (frame_q[0] !== 16'hC3A5) begin failures++; $display("[TB] FAIL drop_word actual=%h required=c3a5", frame_q[0]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL drop_busy actual=%b required=0", busy); end
  endtask

  task automatic test_slow_divider();
    int nack;
    nack = 0;
    wr_word4[15:0] = 16'h8001; req4 = 3'b001;
    for (int c = 0; c < 800 && frame4_q.size() < 2; c++) begin
      @(negedge clock);
      if (ack4[0]) begin
        nack++;
        if (nack == 2) req4 = 3'b000;
      end
    end
    req4 = 3'b000;
    checks++; if (frame4_q.size() != 2) begin failures++; $display("[TB] FAIL slow_frames actual=%0d required=2", frame4_q.size()); end
    if (frame4_q.size() == 2) begin
      checks++; if (frame4_q[0] !== 16'h8001 || frame4_q[1] !== 16'h8001) begin failures++; $display("[TB] FAIL slow_words actual=%h_%h required=8001_8001", frame4_q[0], frame4_q[1]); end
      checks++; if (len4_q[0] != 129) begin failures++; $display("[TB] FAIL slow_sen_low actual=%0d required=129", len4_q[0]); end
      checks++; if (nbits4_q[0] != 16) begin failures++; $display("[TB] FAIL slow_sclk_falls actual=%0d required=16", nbits4_q[0]); end
      checks++; if (gap4_q.size() < 2 || gap4_q[1] != 6) begin failures++; $display("[TB] FAIL slow_gap actual=%0d required=6", (gap4_q.size() > 1) ? gap4_q[1] : -1); end
    end
    checks++; if (hi_min != 4 || hi_max != 4) begin failures++; $display("[TB] FAIL slow_sclk_high actual=%0d..%0d required=4..4", hi_min, hi_max); end
    checks++; if (lo_min != 4 || lo_max != 4) begin failures++; $display("[TB] FAIL slow_sclk_low actual=%0d..%0d required=4..4", lo_min, lo_max); end
    repeat (10) @(negedge clock);
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL slow_busy actual=%b required=0", busy4); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_priority_wrap();
    test_reset_mid_frame();
    test_dropped_req();
    test_slow_divider();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
